temp_ctrl: RTL
==============

Name: temp_ctrl

Overview:
- Memory-mapped temperature-sensor controller at base 0x7004_0000: the bus-responder end of the core's temperature polling protocol.
- Core writes CTRL to start a conversion, then polls STATUS bit0 (busy) until it reads 0, then reads DATA.
- Drives a 3-wire serial sensor (cs_n/sclk/miso), shifts in one DATA_BITS-bit sample per conversion and latches it sign-extended.
- Sits on the peripheral bus beside other 0x70xx_xxxx slaves.

Parameters:
- BASE_ADDR, 32'h7004_0000, decode base; upper 24 bits compared.
- DATA_BITS, 16, sample width shifted from the sensor, 2..32.
- DIV_DEFAULT, 8, reset value of DIV: sclk half-period in clk cycles.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-low reset (`RstEnable = 1'b0)
- req_i  input  1  bus request valid
- we_i  input  1  1 = write, 0 = read
- addr_i  input  32  byte address
- data_i  input  32  write data
- data_o  output  32  read data, combinational from addr_i/req_i
- sensor_cs_n_o  output  1  sensor chip select, active low
- sensor_sclk_o  output  1  serial clock, idle low
- sensor_miso_i  input  1  serial data from sensor, MSB first
- busy_o  output  1  conversion in progress (mirrors STATUS bit0)

Behaviour:
- Decode: hit = req_i && addr_i[31:8] == BASE_ADDR[31:8]; offset = addr_i[7:0].
- Offset 0x00 CTRL/STATUS. Read: bit0 busy, bit1 valid, others 0. Write with data_i[0]=1 starts a conversion.
- Offset 0x04 DATA: read-only, sign-extended sample; writes ignored.
- Offset 0x08 DIV: bits[7:0] read/write; others read 0.
- Reads are combinational, same cycle. Miss, undefined offset, or req_i=0 -> data_o = 0.
- Reset values: busy_o=0, valid=0, DATA=0, DIV=DIV_DEFAULT, sensor_cs_n_o=1, sensor_sclk_o=0, FSM=IDLE.
- Start accepted on the posedge where hit && we_i && offset==0 && data_i[0] && FSM==IDLE.
- Start while busy is ignored; the conversion in progress is unaffected.
- Start write with data_i[0]=0 does nothing.
- On start acceptance: valid<=0; DATA keeps its old value.
- DIV writes are ignored while busy. A written value of 0 is stored as 1.
- FSM IDLE -> SETUP -> SHIFT -> HOLD -> IDLE. Let D = DIV latched at start.
  - SETUP: cs_n=0, sclk=0 for D cycles.
  - SHIFT: DATA_BITS bits. Each bit is sclk low for D cycles, then high for D cycles.
  - miso is sampled into the shift register on the clk edge where sclk goes 0->1, MSB first.
  - After the last high phase, sclk returns to 0 and the FSM moves to HOLD.
  - HOLD: cs_n=1, sclk=0 for D cycles.
  - On exit from HOLD: DATA <= sign-extend(shift reg), valid<=1, busy<=0, all on the same edge.
- busy_o is 1 from the cycle after the accepted start until HOLD exits. Duration = (2*DATA_BITS + 2)*D cycles (272 for defaults).
- Poll read of STATUS in the exit cycle still returns busy=1; the next cycle returns busy=0, valid=1.
- Async reset mid-conversion: all state returns to reset values immediately; cs_n deasserts; the partial sample is discarded.
- A simultaneous read and start in the same cycle returns pre-start status (combinational read of current registers).

Decomposition:
- Shared defines file: TEMP_BASE, offsets TEMP_CTRL/TEMP_DATA/TEMP_DIV, STATUS bit positions BUSY_BIT=0 and VALID_BIT=1, FSM state encodings.
- One natural sub-module: temp_spi_rx, the serial engine (divider counter, bit counter, sclk/cs_n generation, shift register).
  - Interface: start/div in; done/sample out.
  - temp_ctrl keeps decode, registers and the read mux.

Test Plan:
- Reset: hold rst=0 mid-run, release. Read 0x7004_0000 -> 0; read 0x7004_0008 -> 8; read 0x7004_0004 -> 0; cs_n=1, sclk=0.
- Basic conversion, DIV=8, sensor returns 16'h0190. Write 1 to CTRL -> busy=1 next cycle; exactly 16 sclk rising edges; busy falls after 272 cycles; STATUS=0x2; DATA=0x0000_0190.
- Negative sample 16'hFF38, DIV=2 -> conversion takes 68 cycles; DATA reads 0xFFFF_FF38.
- Start while busy, DIV write while busy (0x03), DIV write of 0 when idle:
  - restart and DIV write are ignored; sclk edge count stays 16; DIV reads 8;
  - DIV write of 0 reads back 1.
- Async reset asserted during SHIFT bit 7 -> cs_n=1 within the same cycle, busy=0, DATA unchanged from reset (0); a new start afterwards completes normally.
- Decode: reads to 0x7004_000C, to 0x7005_0000, and with req_i=0 -> data_o=0; a write to DATA has no effect.

Source files
------------

// File: rtl/temp_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : temp_ctrl_pkg
// Brief    : Shared address map, status bit positions and serial FSM states.
// Revision : 1.0
// ============================================================================
package temp_ctrl_pkg;

    localparam logic [31:0] TEMP_BASE = 32'h7004_0000;
    localparam logic [7:0]  TEMP_CTRL = 8'h00;
    localparam logic [7:0]  TEMP_DATA = 8'h04;
    localparam logic [7:0]  TEMP_DIV  = 8'h08;

    localparam int BUSY_BIT  = 0;
    localparam int VALID_BIT = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_HOLD  = 2'd3
    } spi_state_t;

endpackage : temp_ctrl_pkg
`default_nettype wire

// File: rtl/temp_spi_rx.sv
`default_nettype none
// ============================================================================
// Module   : temp_spi_rx
// Brief    : 3-wire sensor receive engine: cs_n/sclk generation, MSB-first shift.
// Revision : 1.0
// ============================================================================
module temp_spi_rx
    import temp_ctrl_pkg::*;
#(
    parameter int DATA_BITS = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    input  logic [7:0]           i_div,
    input  logic                 i_miso,
    output logic                 o_idle,
    output logic                 o_done,
    output logic [DATA_BITS-1:0] o_sample,
    output logic                 o_cs_n,
    output logic                 o_sclk
);

    localparam int c_BW = $clog2(DATA_BITS);

    spi_state_t           r_state;
    logic [7:0]           r_div;
    logic [7:0]           r_cnt;
    logic [c_BW-1:0]      r_bit;
    logic                 r_sclk;
    logic                 r_cs_n;
    logic [DATA_BITS-1:0] r_shift;
    logic                 w_last;

    // Every phase (setup, sclk low, sclk high, hold) lasts r_div cycles.
    assign w_last = (r_cnt == r_div - 8'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_div   <= 8'd1;
            r_cnt   <= 8'd0;
            r_bit   <= '0;
            r_sclk  <= 1'b0;
            r_cs_n  <= 1'b1;
            r_shift <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_state <= ST_SETUP;
                        r_div   <= i_div;
                        r_cnt   <= 8'd0;
                        r_bit   <= '0;
                        r_cs_n  <= 1'b0;
                    end
                end
                ST_SETUP: begin
                    if (w_last) begin
                        r_state <= ST_SHIFT;
                        r_cnt   <= 8'd0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_SHIFT: begin
                    if (w_last) begin
                        r_cnt <= 8'd0;
                        if (!r_sclk) begin
                            r_sclk  <= 1'b1;
                            r_shift <= {r_shift[DATA_BITS-2:0], i_miso};
                        end else begin
                            r_sclk <= 1'b0;
                            if (r_bit == c_BW'(DATA_BITS - 1)) begin
                                r_state <= ST_HOLD;
                                r_cs_n  <= 1'b1;
                            end else begin
                                r_bit <= r_bit + 1'b1;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_HOLD: begin
                    if (w_last) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_idle   = (r_state == ST_IDLE);
    assign o_done   = (r_state == ST_HOLD) && w_last;
    assign o_sample = r_shift;
    assign o_cs_n   = r_cs_n;
    assign o_sclk   = r_sclk;

endmodule : temp_spi_rx
`default_nettype wire

// File: rtl/temp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : temp_ctrl
// Brief    : Bus-mapped temperature sensor controller (CTRL/STATUS, DATA, DIV).
// Revision : 1.0
// ============================================================================
module temp_ctrl
    import temp_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = TEMP_BASE,
    parameter int          DATA_BITS   = 16,
    parameter logic [7:0]  DIV_DEFAULT = 8'd8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        sensor_cs_n_o,
    output logic        sensor_sclk_o,
    input  logic        sensor_miso_i,
    output logic        busy_o
);

    logic                 r_busy;
    logic                 r_valid;
    logic [31:0]          r_data;
    logic [7:0]           r_div;
    logic                 w_hit;
    logic [7:0]           w_off;
    logic                 w_start;
    logic                 w_div_wr;
    logic                 w_idle;
    logic                 w_done;
    logic [DATA_BITS-1:0] w_sample;
    logic [31:0]          w_sext;
    logic                 w_unused_data;

    assign w_hit         = req_i && (addr_i[31:8] == BASE_ADDR[31:8]);
    assign w_off         = addr_i[7:0];
    assign w_start       = w_hit && we_i && (w_off == TEMP_CTRL) && data_i[0] && w_idle;
    assign w_div_wr      = w_hit && we_i && (w_off == TEMP_DIV) && !r_busy;
    assign w_unused_data = &{1'b0, data_i[31:8]};

    generate
        if (DATA_BITS < 32) begin : g_sext
            assign w_sext = {{(32 - DATA_BITS){w_sample[DATA_BITS-1]}}, w_sample};
        end else begin : g_full
            assign w_sext = w_sample;
        end
    endgenerate

    temp_spi_rx #(
        .DATA_BITS (DATA_BITS)
    ) u_spi_rx (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_start),
        .i_div    (r_div),
        .i_miso   (sensor_miso_i),
        .o_idle   (w_idle),
        .o_done   (w_done),
        .o_sample (w_sample),
        .o_cs_n   (sensor_cs_n_o),
        .o_sclk   (sensor_sclk_o)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_data  <= 32'd0;
            r_div   <= DIV_DEFAULT;
        end else begin
            if (w_start) begin
                r_busy  <= 1'b1;
                r_valid <= 1'b0;
            end else if (w_done) begin
                r_busy  <= 1'b0;
                r_valid <= 1'b1;
                r_data  <= w_sext;
            end
            // A zero divider would stall the engine, so it is clamped to 1.
            if (w_div_wr) begin
                r_div <= (data_i[7:0] == 8'd0) ? 8'd1 : data_i[7:0];
            end
        end
    end

    always_comb begin
        data_o = 32'd0;
        if (w_hit) begin
            case (w_off)
                TEMP_CTRL: begin
                    data_o[BUSY_BIT]  = r_busy;
                    data_o[VALID_BIT] = r_valid;
                end
                TEMP_DATA: data_o = r_data;
                TEMP_DIV:  data_o = {24'd0, r_div};
                default:   data_o = 32'd0;
            endcase
        end
    end

    assign busy_o = r_busy;

endmodule : temp_ctrl
`default_nettype wire
